// File: rtl/uart_tx_serializer_if.sv
// ----------------------------------------------------------------------------
// uart_tx_serializer_if
// Read-side link between the transmit byte FIFO and the UART serializer.
//   fifo_data    : FIFO registered data output, valid the cycle after a strobe
//   fifo_p_empty : FIFO empty flag, active high
//   fifo_n_re    : read strobe, active low, one-cycle pulse
// Modports:
//   master : serializer side (drives the read strobe)
//   slave  : FIFO side (drives data and empty flag)
// ----------------------------------------------------------------------------
interface uart_tx_serializer_if;
    logic [7:0] fifo_data;
    logic       fifo_p_empty;
    logic       fifo_n_re;

    modport master (
        input  fifo_data,
        input  fifo_p_empty,
        output fifo_n_re
    );

    modport slave (
        output fifo_data,
        output fifo_p_empty,
        input  fifo_n_re
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// ----------------------------------------------------------------------------
// uart_tx_serializer
// Pops bytes from the transmit FIFO and shifts them onto the UART TX line:
// start bit, 8 data bits LSB-first, optional parity, 1 or 2 stop bits.
// Ports:
//   clk, rst      : system clock, asynchronous active-high reset
//   enable_i      : permits a new frame to start (sampled in idle only)
//   fifo          : FIFO read link (data, empty flag, active-low read strobe)
//   parity_en_i   : append a parity bit
//   parity_odd_i  : 1 = odd parity, 0 = even parity
//   stop2_i       : 1 = two stop bits
//   tx_o          : serial line, idles high
//   busy_o        : high whenever not idle
//   frame_done_o  : one-cycle pulse in the last clock of the final stop bit
// All outputs are registered; config inputs are latched once per frame.
// ----------------------------------------------------------------------------
module uart_tx_serializer #(
    parameter logic [15:0] BAUD_DIV = 16'd347
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable_i,
    uart_tx_serializer_if.master        fifo,
    input  logic                        parity_en_i,
    input  logic                        parity_odd_i,
    input  logic                        stop2_i,
    output logic                        tx_o,
    output logic                        busy_o,
    output logic                        frame_done_o
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLoad,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e      state_q;
    logic [15:0] cnt_q;
    logic [7:0]  shift_q;
    logic [2:0]  bit_idx_q;
    logic        par_en_q;
    logic        stop2_q;
    logic        parity_bit_q;
    logic        tx_q;
    logic        n_re_q;
    logic        busy_q;
    logic        done_q;

    logic        bit_tick;
    logic        counting;
    logic        last_stop;

    assign bit_tick  = (cnt_q == BAUD_DIV - 16'd1);
    assign counting  = (state_q == StStart) || (state_q == StData) ||
                       (state_q == StParity) || (state_q == StStop);
    assign last_stop = stop2_q ? (bit_idx_q == 3'd1) : (bit_idx_q == 3'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= 16'd0;
            shift_q      <= 8'd0;
            bit_idx_q    <= 3'd0;
            par_en_q     <= 1'b0;
            stop2_q      <= 1'b0;
            parity_bit_q <= 1'b0;
            tx_q         <= 1'b1;
            n_re_q       <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            n_re_q <= 1'b1;
            done_q <= 1'b0;

            if (counting) begin
                cnt_q <= bit_tick ? 16'd0 : cnt_q + 16'd1;
            end

            case (state_q)
                StIdle: begin
                    tx_q <= 1'b1;
                    if (enable_i && !fifo.fifo_p_empty) begin
                        state_q <= StFetch;
                        n_re_q  <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end

                // Strobe is already on the line this cycle; FIFO data lands next cycle.
                StFetch: begin
                    state_q <= StLoad;
                end

                StLoad: begin
                    shift_q      <= fifo.fifo_data;
                    par_en_q     <= parity_en_i;
                    stop2_q      <= stop2_i;
                    parity_bit_q <= (^fifo.fifo_data) ^ parity_odd_i;
                    cnt_q        <= 16'd0;
                    bit_idx_q    <= 3'd0;
                    tx_q         <= 1'b0;
                    state_q      <= StStart;
                end

                // tx_q is registered, so each bit is loaded on the tick ending the
                // previous bit; the shift register therefore runs one bit ahead.
                StStart: begin
                    if (bit_tick) begin
                        tx_q    <= shift_q[0];
                        shift_q <= {1'b0, shift_q[7:1]};
                        state_q <= StData;
                    end
                end

                StData: begin
                    if (bit_tick) begin
                        if (bit_idx_q == 3'd7) begin
                            bit_idx_q <= 3'd0;
                            if (par_en_q) begin
                                tx_q    <= parity_bit_q;
                                state_q <= StParity;
                            end else begin
                                tx_q    <= 1'b1;
                                state_q <= StStop;
                            end
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            tx_q      <= shift_q[0];
                            shift_q   <= {1'b0, shift_q[7:1]};
                        end
                    end
                end

                StParity: begin
                    if (bit_tick) begin
                        tx_q      <= 1'b1;
                        bit_idx_q <= 3'd0;
                        state_q   <= StStop;
                    end
                end

                StStop: begin
                    // Set one clock early so the registered pulse lines up with the tick.
                    if (last_stop && (cnt_q == BAUD_DIV - 16'd2)) begin
                        done_q <= 1'b1;
                    end
                    if (bit_tick) begin
                        if (last_stop) begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign fifo.fifo_n_re = n_re_q;
    assign tx_o           = tx_q;
    assign busy_o         = busy_q;
    assign frame_done_o   = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_serializer
// Self-checking bench for uart_tx_serializer with BAUD_DIV = 4. A behavioural
// FIFO feeds the DUT; expected per-clock traces of tx/n_re/done/busy are built
// from the frame format (bit list times bit period) and compared cycle by cycle.
// ----------------------------------------------------------------------------
module tb_uart_tx_serializer;

    localparam int BD    = 4;
    localparam int TRACE = 200;

    logic clk;
    logic rst;
    logic enable_i;
    logic parity_en_i;
    logic parity_odd_i;
    logic stop2_i;
    logic tx_o;
    logic busy_o;
    logic frame_done_o;

    uart_tx_serializer_if bus ();

    uart_tx_serializer #(
        .BAUD_DIV (16'(BD))
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable_i     (enable_i),
        .fifo         (bus.master),
        .parity_en_i  (parity_en_i),
        .parity_odd_i (parity_odd_i),
        .stop2_i      (stop2_i),
        .tx_o         (tx_o),
        .busy_o       (busy_o),
        .frame_done_o (frame_done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int read_cnt = 0;

    logic [7:0] fifo_q[$];
    logic [7:0] exp_bytes[$];

    // Per cycle: {busy, done, n_re, tx}
    logic [3:0] act_tr[TRACE];
    logic [3:0] exp_tr[TRACE];
    string      sig_name[4] = '{"tx", "n_re", "frame_done", "busy"};

    // Behavioural FIFO: a strobe seen low pops the head onto the data output.
    always @(negedge clk) begin
        if (!rst && bus.fifo_n_re === 1'b0) begin
            read_cnt++;
            if (fifo_q.size() > 0) bus.fifo_data = fifo_q.pop_front();
            else                   bus.fifo_data = 8'h00;
        end
        bus.fifo_p_empty = (fifo_q.size() == 0);
    end

    task automatic push_byte(input logic [7:0] b);
        fifo_q.push_back(b);
        bus.fifo_p_empty = 1'b0;
    endtask

    // Expected traces from the frame format, starting at the first FETCH cycle.
    function automatic void build_expected(input bit pen, input bit podd, input bit s2);
        int   p;
        int   nb;
        int   ones;
        logic b[12];
        for (int i = 0; i < TRACE; i++) exp_tr[i] = 4'b0011;
        p = 0;
        foreach (exp_bytes[k]) begin
            nb   = 0;
            b[0] = 1'b0;
            nb   = 1;
            for (int j = 0; j < 8; j++) begin
                b[nb] = exp_bytes[k][j];
                nb    = nb + 1;
            end
            ones = $countones(exp_bytes[k]);
            if (pen) begin
                b[nb] = podd ? (ones % 2 == 0) : (ones % 2 == 1);
                nb    = nb + 1;
            end
            b[nb] = 1'b1;
            nb    = nb + 1;
            if (s2) begin
                b[nb] = 1'b1;
                nb    = nb + 1;
            end
            exp_tr[p][1] = 1'b0;
            for (int c = p; c <= p + 1 + nb * BD; c++) exp_tr[c][3] = 1'b1;
            for (int j = 0; j < nb; j++)
                for (int c = 0; c < BD; c++) exp_tr[p + 2 + j * BD + c][0] = b[j];
            exp_tr[p + 1 + nb * BD][2] = 1'b1;
            p = p + 3 + nb * BD;
        end
    endfunction

    function automatic int first_diff(input int s);
        for (int i = 0; i < TRACE; i++)
            if (act_tr[i][s] !== exp_tr[i][s]) return i;
        return -1;
    endfunction

    // Waits (bounded) for the read strobe, then records TRACE cycles from it.
    // Optionally flips config at cfg_at or drops enable at en_at.
    task automatic record(input int cfg_at, input int en_at, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (bus.fifo_n_re === 1'b0) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) return;
        for (int i = 0; i < TRACE; i++) begin
            if (i > 0) @(negedge clk);
            act_tr[i] = {busy_o, frame_done_o, bus.fifo_n_re, tx_o};
            if (i == cfg_at) begin
                parity_odd_i = ~parity_odd_i;
                parity_en_i  = ~parity_en_i;
                stop2_i      = ~stop2_i;
            end
            if (i == en_at) enable_i = 1'b0;
        end
    endtask

    task automatic run_burst(input bit pen, input bit podd, input bit s2,
                             input int cfg_at, input int en_at, output bit seen);
        @(negedge clk);
        enable_i     = 1'b0;
        parity_en_i  = pen;
        parity_odd_i = podd;
        stop2_i      = s2;
        read_cnt     = 0;
        foreach (exp_bytes[k]) push_byte(exp_bytes[k]);
        build_expected(pen, podd, s2);
        enable_i = 1'b1;
        record(cfg_at, en_at, seen);
        enable_i = 1'b0;
    endtask

    task automatic test_reset();
        int bad_tx;
        int bad_busy;
        int bad_re;
        rst      = 1'b1;
        enable_i = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (tx_o !== 1'b1 || busy_o !== 1'b0 || frame_done_o !== 1'b0 || bus.fifo_n_re !== 1'b1) begin
            errors++;
            $display("FAIL reset_values: tx=%b busy=%b done=%b n_re=%b, want 1 0 0 1",
                     tx_o, busy_o, frame_done_o, bus.fifo_n_re);
        end
        rst      = 1'b0;
        bad_tx   = 0;
        bad_busy = 0;
        bad_re   = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx_o !== 1'b1) bad_tx++;
            if (busy_o !== 1'b0) bad_busy++;
            if (bus.fifo_n_re !== 1'b1) bad_re++;
        end
        checks++;
        if (bad_tx !== 0) begin
            errors++;
            $display("FAIL empty_idle_tx: %0d cycles with tx low, want 0", bad_tx);
        end
        checks++;
        if (bad_busy !== 0) begin
            errors++;
            $display("FAIL empty_idle_busy: %0d cycles busy, want 0", bad_busy);
        end
        checks++;
        if (bad_re !== 0) begin
            errors++;
            $display("FAIL empty_idle_strobe: %0d strobe cycles, want 0", bad_re);
        end
        enable_i = 1'b0;
    endtask

    task automatic check_traces(input string tag, input bit seen, input int want_reads);
        int d;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_strobe_timeout: no read strobe within 500 cycles", tag);
            return;
        end
        for (int s = 0; s < 4; s++) begin
            checks++;
            d = first_diff(s);
            if (d >= 0) begin
                errors++;
                $display("FAIL %s_%s: cycle %0d got %b want %b", tag, sig_name[s], d,
                         act_tr[d][s], exp_tr[d][s]);
            end
        end
        checks++;
        if (read_cnt !== want_reads) begin
            errors++;
            $display("FAIL %s_reads: got %0d want %0d", tag, read_cnt, want_reads);
        end
    endtask

    task automatic test_basic();
        bit seen;
        exp_bytes = '{8'hA5};
        run_burst(1'b0, 1'b0, 1'b0, -1, -1, seen);
        check_traces("a5_frame", seen, 1);
        checks++;
        if (act_tr[41][2] !== 1'b1 || act_tr[42][3] !== 1'b0 || act_tr[2][0] !== 1'b0) begin
            errors++;
            $display("FAIL a5_timing: done@41=%b busy@42=%b tx@2=%b, want 1 0 0",
                     act_tr[41][2], act_tr[42][3], act_tr[2][0]);
        end
    endtask

    task automatic test_parity();
        bit seen;
        exp_bytes = '{8'h07};
        run_burst(1'b1, 1'b0, 1'b0, -1, -1, seen);
        check_traces("par_even", seen, 1);
        checks++;
        if (act_tr[2 + 9 * BD][0] !== 1'b1 || act_tr[45][2] !== 1'b1) begin
            errors++;
            $display("FAIL par_even_bit: parity=%b done@45=%b, want 1 1",
                     act_tr[2 + 9 * BD][0], act_tr[45][2]);
        end
        run_burst(1'b1, 1'b1, 1'b0, -1, -1, seen);
        check_traces("par_odd", seen, 1);
        checks++;
        if (act_tr[2 + 9 * BD][0] !== 1'b0) begin
            errors++;
            $display("FAIL par_odd_bit: parity=%b want 0", act_tr[2 + 9 * BD][0]);
        end
    endtask

    task automatic test_stop2();
        bit seen;
        exp_bytes = '{8'h00};
        run_burst(1'b0, 1'b0, 1'b1, -1, -1, seen);
        check_traces("stop2", seen, 1);
        checks++;
        if (act_tr[45][2] !== 1'b1 || act_tr[44][0] !== 1'b1 || act_tr[37][0] !== 1'b0) begin
            errors++;
            $display("FAIL stop2_shape: done@45=%b tx@44=%b tx@37=%b, want 1 1 0",
                     act_tr[45][2], act_tr[44][0], act_tr[37][0]);
        end
    endtask

    task automatic test_back_to_back();
        bit seen;
        exp_bytes = '{8'h11, 8'h22};
        run_burst(1'b0, 1'b0, 1'b0, -1, -1, seen);
        check_traces("b2b", seen, 2);
        checks++;
        if (act_tr[43][1] !== 1'b0 || act_tr[45][0] !== 1'b0 || act_tr[44][0] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_gap: n_re@43=%b tx@45=%b tx@44=%b, want 0 0 1",
                     act_tr[43][1], act_tr[45][0], act_tr[44][0]);
        end
    endtask

    task automatic test_random();
        bit seen;
        bit pen;
        bit podd;
        bit s2;
        int n;
        for (int it = 0; it < 5; it++) begin
            exp_bytes.delete();
            n = $urandom_range(3, 1);
            for (int k = 0; k < n; k++) exp_bytes.push_back(8'($urandom));
            pen  = 1'($urandom);
            podd = 1'($urandom);
            s2   = 1'($urandom);
            run_burst(pen, podd, s2, -1, -1, seen);
            check_traces($sformatf("rand%0d", it), seen, n);
        end
    endtask

    task automatic test_enable_drop();
        bit seen;
        exp_bytes = '{8'h3C, 8'hC3};
        run_burst(1'b1, 1'b0, 1'b0, -1, 10, seen);
        exp_bytes = '{8'h3C};
        build_expected(1'b1, 1'b0, 1'b0);
        check_traces("en_drop", seen, 1);
        checks++;
        if (fifo_q.size() !== 1) begin
            errors++;
            $display("FAIL en_drop_left: fifo holds %0d want 1", fifo_q.size());
        end
        fifo_q.delete();
        bus.fifo_p_empty = 1'b1;
    endtask

    task automatic test_cfg_midframe();
        bit seen;
        exp_bytes = '{8'h6B};
        run_burst(1'b1, 1'b0, 1'b0, 20, -1, seen);
        check_traces("cfg_mid", seen, 1);
    endtask

    task automatic test_reset_midframe();
        bit seen;
        int bad;
        @(negedge clk);
        parity_en_i  = 1'b0;
        parity_odd_i = 1'b0;
        stop2_i      = 1'b0;
        read_cnt     = 0;
        push_byte(8'hA5);
        enable_i = 1'b1;
        seen     = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (bus.fifo_n_re === 1'b0) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL rst_mid_strobe_timeout: no read strobe within 500 cycles");
            return;
        end
        repeat (19) @(negedge clk);
        checks++;
        if (tx_o !== 1'b0 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_pre: tx=%b busy=%b, want 0 1 (data bit 3)", tx_o, busy_o);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (tx_o !== 1'b1 || busy_o !== 1'b0 || frame_done_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_async: tx=%b busy=%b done=%b, want 1 0 0",
                     tx_o, busy_o, frame_done_o);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (bus.fifo_n_re !== 1'b1 || tx_o !== 1'b1 || busy_o !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0 || read_cnt !== 1) begin
            errors++;
            $display("FAIL rst_mid_after: %0d active cycles, %0d reads, want 0 and 1",
                     bad, read_cnt);
        end
        enable_i = 1'b0;
    endtask

    initial begin
        rst              = 1'b1;
        enable_i         = 1'b0;
        parity_en_i      = 1'b0;
        parity_odd_i     = 1'b0;
        stop2_i          = 1'b0;
        bus.fifo_data    = 8'h00;
        bus.fifo_p_empty = 1'b1;

        test_reset();
        test_basic();
        test_parity();
        test_stop2();
        test_back_to_back();
        test_random();
        test_enable_drop();
        test_cfg_midframe();
        test_reset_midframe();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
